// File: rtl/i2s_pkg.sv
// i2s_pkg: shared framing modes and counter-width helper for the I2S transmitter
package i2s_pkg;
  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/i2s_frame_fifo.sv
// i2s_frame_fifo: synchronous FIFO of {left, right} stereo frames
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] data
);
  localparam int AW = cw(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign data  = mem_q[rp_q];
  // Frame storage; contents need no reset since the count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr_data;
  end
  // Pointers and occupancy; push and pop in one clk are both honoured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: stereo I2S / left-justified serialiser with frame FIFO and integer bclk divider
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int MODE       = MODE_I2S
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_left,
  input  logic [SAMPLE_W-1:0] sample_right,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                mute,
  output logic                bclk,
  output logic                lrclk,
  output logic                din,
  output logic                underrun
);
  localparam int DW = cw(BCLK_DIV);
  localparam int PW = cw(2*SLOT_W);
  localparam logic [PW-1:0] P_LAST = PW'(2*SLOT_W-1);
  if (SLOT_W < SAMPLE_W) begin : g_chk_slot
    $error("i2s_tx: SLOT_W must be >= SAMPLE_W");
  end
  if (BCLK_DIV < 2) begin : g_chk_div
    $error("i2s_tx: BCLK_DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_chk_depth
    $error("i2s_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  logic [DW-1:0]         div_q, div_d;
  logic [PW-1:0]         p_q, p_d, off;
  logic                  bclk_q, bclk_d, lr_q, lr_d, din_q, din_d, ur_q, ur_d;
  logic [2*SAMPLE_W-1:0] frame_q, frame_d, head;
  logic [SAMPLE_W-1:0]   word, shifted;
  logic                  tick, fall, load, full, empty, push, pop;
  assign sample_ready = rst_n & ~full;
  assign push         = sample_valid & sample_ready;
  assign pop          = load & ~empty;
  assign bclk         = bclk_q;
  assign lrclk        = lr_q;
  assign din          = din_q;
  assign underrun     = ur_q;
  i2s_frame_fifo #(.WIDTH(2*SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wr_data ({sample_left, sample_right}),
    .full    (full),
    .empty   (empty),
    .data    (head)
  );
  // Divider, bit position and frame load; din/lrclk are computed from the post-fall position.
  always_comb begin
    tick    = div_q == DW'(BCLK_DIV-1);
    fall    = tick & bclk_q;
    div_d   = tick ? '0 : div_q + DW'(1);
    bclk_d  = bclk_q ^ tick;
    p_d     = !fall ? p_q : (p_q == P_LAST) ? '0 : p_q + PW'(1);
    load    = fall & (p_d == '0);
    frame_d = !load ? frame_q : empty ? '0 : head;
    ur_d    = load & empty;
    off     = (p_d >= PW'(SLOT_W)) ? p_d - PW'(SLOT_W) : p_d;
    word    = (p_d >= PW'(SLOT_W)) ? frame_d[SAMPLE_W-1:0] : frame_d[2*SAMPLE_W-1 -: SAMPLE_W];
    shifted = word << off;
    din_d   = fall ? ~mute & shifted[SAMPLE_W-1] : din_q;
    lr_d    = !fall ? lr_q :
              (MODE == MODE_LJ) ? p_d >= PW'(SLOT_W) :
              (p_d >= PW'(SLOT_W-1)) && (p_d <= PW'(2*SLOT_W-2));
  end
  // Serial-side state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q   <= '0;
      p_q     <= P_LAST;
      bclk_q  <= 1'b0;
      lr_q    <= MODE == MODE_LJ;
      din_q   <= 1'b0;
      ur_q    <= 1'b0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      p_q     <= p_d;
      bclk_q  <= bclk_d;
      lr_q    <= lr_d;
      din_q   <= din_d;
      ur_q    <= ur_d;
      frame_q <= frame_d;
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: randomized check of i2s_tx (both framing modes) against a time-indexed reference model
module tb_i2s_tx;
  localparam int SW = 16, S = 32, D = 6, DEPTH = 4;
  localparam int FRAME = 4*D*S;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [SW-1:0] sl = '0, sr = '0;
  logic sv = 1'b0, mute = 1'b0;
  logic rdy0, bclk0, lr0, din0, ur0;
  logic rdy1, bclk1, lr1, din1, ur1;
  int n_run = 0, n_fail = 0;
  logic [2*SW-1:0] mq[$], src[$];
  logic [2*SW-1:0] cur = '0;
  int n = 0, p = 2*S-1, falls = 0;
  logic e_bclk = 0, e_lr0 = 0, e_lr1 = 1, e_din = 0, e_ur = 0;

  always #5 clk = ~clk;

  i2s_tx #(.SAMPLE_W(SW), .SLOT_W(S), .BCLK_DIV(D), .FIFO_DEPTH(DEPTH), .MODE(0)) u_i2s (
    .clk(clk), .rst_n(rst_n), .sample_left(sl), .sample_right(sr), .sample_valid(sv),
    .sample_ready(rdy0), .mute(mute), .bclk(bclk0), .lrclk(lr0), .din(din0), .underrun(ur0));
  i2s_tx #(.SAMPLE_W(SW), .SLOT_W(S), .BCLK_DIV(D), .FIFO_DEPTH(DEPTH), .MODE(1)) u_lj (
    .clk(clk), .rst_n(rst_n), .sample_left(sl), .sample_right(sr), .sample_valid(sv),
    .sample_ready(rdy1), .mute(mute), .bclk(bclk1), .lrclk(lr1), .din(din1), .underrun(ur1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bit of the frame that belongs at slot position pos.
  function automatic logic bit_at(input logic [2*SW-1:0] f, input int pos);
    int k;
    logic [SW-1:0] w;
    k = pos < S ? pos : pos - S;
    w = pos < S ? f[2*SW-1 -: SW] : f[SW-1:0];
    return k < SW ? w[SW-1-k] : 1'b0;
  endfunction

  // One clk: check ready, advance the model by the edge, check registered outputs, drive inputs.
  task automatic step();
    bit acc;
    #1;
    acc = rst_n && sv && mq.size() < DEPTH;
    check("ready0", rdy0, rst_n && mq.size() < DEPTH);
    check("ready1", rdy1, rst_n && mq.size() < DEPTH);
    @(posedge clk);
    e_ur = 0;
    if (!rst_n) begin
      n = 0; p = 2*S-1; mq.delete(); cur = '0;
      e_bclk = 0; e_din = 0; e_lr0 = 0; e_lr1 = 1;
    end else begin
      n++;
      if (n % D == 0) begin
        e_bclk = ((n / D) % 2) == 1;
        if (!e_bclk) begin
          falls++;
          p = ((n / (2*D)) - 1) % (2*S);
          if (p == 0) begin
            e_ur = mq.size() == 0;
            if (e_ur) cur = '0;
            else cur = mq.pop_front();
          end
          e_din = !mute && bit_at(cur, p);
          e_lr0 = p >= S-1 && p <= 2*S-2;
          e_lr1 = p >= S;
        end
      end
      if (acc) begin
        mq.push_back({sl, sr});
        void'(src.pop_front());
      end
    end
    #1;
    check("bclk0", bclk0, e_bclk);
    check("bclk1", bclk1, e_bclk);
    check("lrclk0", lr0, e_lr0);
    check("lrclk1", lr1, e_lr1);
    check("din0", din0, e_din);
    check("din1", din1, e_din);
    check("underrun0", ur0, e_ur);
    check("underrun1", ur1, e_ur);
    sv = src.size() > 0;
    if (sv) {sl, sr} = src[0];
  endtask

  task automatic run_to_p(input int target);
    int i = 0;
    do begin step(); i++; end while (p != target && i < 2*FRAME);
    check("wait_p", p, target);
  endtask

  task automatic run_falls(input int k);
    int f0 = falls;
    for (int i = 0; i < 2*FRAME && falls < f0 + k; i++) step();
    check("wait_falls", falls - f0, k);
  endtask

  initial begin
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2*FRAME) step();
    src.push_back({16'hA5C3, 16'h0F0F});
    repeat (4) src.push_back((2*SW)'($urandom));
    repeat (6*FRAME) step();
    for (int i = 0; i < 8*FRAME && (src.size() > 0 || mq.size() > 0); i++) step();
    check("drain", mq.size() + src.size(), 0);
    src.push_back({16'h7FFF, 16'h7FFF});
    run_to_p(2*S-1);
    mute = 1'b1;
    run_falls(2*S);
    mute = 1'b0;
    src.push_back((2*SW)'($urandom));
    repeat (2*FRAME) step();
    for (int i = 0; i < 20*FRAME; i++) begin
      if (src.size() == 0 && $urandom_range(0, 599) == 0) src.push_back((2*SW)'($urandom));
      if ($urandom_range(0, 299) == 0) mute = ~mute;
      step();
    end
    mute = 1'b0;
    repeat (3) src.push_back((2*SW)'($urandom));
    run_to_p(10);
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2*FRAME) step();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
